// File: rtl/pmem_arbiter_pkg.sv
// Shared types and default widths for the icache/dcache physical-memory arbiter.
package pmem_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int LINE_WIDTH_DEF = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

endpackage

// File: rtl/pmem_arbiter_select.sv
// Grant policy for the pmem arbiter: on a tie the requester that was not granted last wins.
// A caller that pins i_last_grant to REQ_I gets fixed d-over-i priority.
module pmem_arbiter_select
    import pmem_arbiter_pkg::*;
(
    input  logic     i_icache_req,
    input  logic     i_dcache_req,
    input  arb_req_t i_last_grant,
    output logic     o_grant_valid,
    output arb_req_t o_grant
);

    always_comb begin
        o_grant_valid = i_icache_req | i_dcache_req;
        o_grant       = REQ_D;
        if (i_icache_req && i_dcache_req) begin
            o_grant = (i_last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (i_icache_req) begin
            o_grant = REQ_I;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical memory port between icache and dcache, one request in service at a time.
// Optional round-robin tie-break enabled by defining PMEM_ARBITER_RR_EN.
//
// state   | meaning
// IDLE    | no grant; pmem outputs 0; picks next requester
// SERVE_I | icache forwarded to pmem; i_resp follows pmem_resp
// SERVE_D | dcache forwarded to pmem; d_resp follows pmem_resp
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    arb_req_t   w_last_grant;
    arb_req_t   w_grant;
    logic       w_grant_valid;

    pmem_arbiter_select u_select (
        .i_icache_req (i_read | i_write),
        .i_dcache_req (d_read | d_write),
        .i_last_grant (w_last_grant),
        .o_grant_valid(w_grant_valid),
        .o_grant      (w_grant)
    );

`ifdef PMEM_ARBITER_RR_EN
    arb_req_t r_last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= REQ_I;
        end else if (r_state != IDLE && pmem_resp) begin
            r_last_grant <= (r_state == SERVE_D) ? REQ_D : REQ_I;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    // Pinned to I so the selector always hands ties to the dcache.
    assign w_last_grant = REQ_I;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = (w_grant == REQ_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                pmem_read    = i_read;
                pmem_write   = i_write;
                pmem_address = i_address;
                pmem_wdata   = i_wdata;
                i_resp       = pmem_resp;
                if (pmem_resp) begin
                    w_next_state = IDLE;
                end
            end
            SERVE_D: begin
                pmem_read    = d_read;
                pmem_write   = d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                d_resp       = pmem_resp;
                if (pmem_resp) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Data is never muxed: resp alone says which cache may take it.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

`ifndef SYNTHESIS
    a_i_rw_excl: assert property (@(posedge clk) disable iff (reset) !(i_read && i_write))
        else $error("icache asserted read and write together");
    a_d_rw_excl: assert property (@(posedge clk) disable iff (reset) !(d_read && d_write))
        else $error("dcache asserted read and write together");
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: a line memory model with variable latency,
// cache-side transaction tasks, a table of grant vectors and randomized rounds.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_read, i_write, d_read, d_write;
    logic [15:0]  i_address, d_address, pmem_address;
    logic [127:0] i_wdata, d_wdata, i_rdata, d_rdata, pmem_wdata, pmem_rdata;
    logic         i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 2;
    int arb_last = 0;   // 0 = icache, 1 = dcache: who completed most recently
    int log_q[$];
    int n_reads = 0, gap_err = 0, both_err = 0, spur_err = 0;
    logic prev_resp = 1'b0, prev_rd = 1'b0;

    logic [127:0] ref_mem [int];
    logic [127:0] mem [4096];
    bit           wr_valid [4096];
    int           cnt;

    pmem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] line_init(input logic [15:0] a);
        return {8{a ^ 16'hA5C3}};
    endfunction

    function automatic logic [127:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return line_init(a);
    endfunction

    // Fixed priority hands ties to d; round robin hands them to whoever did not finish last.
    function automatic int exp_winner(input bit ireq, input bit dreq);
        if (ireq && dreq) begin
`ifdef PMEM_ARBITER_RR_EN
            return (arb_last == 0) ? 1 : 0;
`else
            return 1;
`endif
        end
        return dreq ? 1 : 0;
    endfunction

    // Physical memory: answers after lat cycles of a held request, one-cycle resp pulse.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            cnt        <= 0;
        end else if (pmem_resp) begin
            pmem_resp <= 1'b0;
            cnt       <= 0;
        end else if (pmem_read || pmem_write) begin
            if (cnt >= lat - 1) begin
                pmem_resp <= 1'b1;
                cnt       <= 0;
                if (pmem_write) begin
                    mem[pmem_address[15:4]]      <= pmem_wdata;
                    wr_valid[pmem_address[15:4]] <= 1'b1;
                    pmem_rdata                   <= pmem_wdata;
                end else begin
                    pmem_rdata <= wr_valid[pmem_address[15:4]] ? mem[pmem_address[15:4]]
                                                               : line_init(pmem_address);
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    // Protocol monitor: completion order, one resp at a time, IDLE cycle after every completion.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (i_resp) log_q.push_back(0);
                if (d_resp) log_q.push_back(1);
                if (i_resp && d_resp) both_err++;
                if ((i_resp || d_resp) && !pmem_resp) spur_err++;
                if (prev_resp && (pmem_read || pmem_write)) gap_err++;
                if (pmem_read && !prev_rd) n_reads++;
            end
            prev_resp = pmem_resp;
            prev_rd   = pmem_read;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // One cache transaction; hold = extra cycles the request stays up after resp.
    task automatic txn(input int side, input bit wr, input logic [15:0] a,
                       input logic [127:0] wd, input int hold);
        bit    got = 1'b0;
        string tag = (side == 0) ? "i" : "d";
        if (side == 0) begin
            i_read = !wr; i_write = wr; i_address = a; i_wdata = wd;
        end else begin
            d_read = !wr; d_write = wr; d_address = a; d_wdata = wd;
        end
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if ((side == 0) ? i_resp : d_resp) begin
                got = 1'b1;
                chk({tag, "_addr"}, 128'(pmem_address), 128'(a));
                chk({tag, "_wr"}, 128'(pmem_write), 128'(wr));
                chk({tag, "_other_resp"}, 128'((side == 0) ? d_resp : i_resp), 128'(0));
                if (wr) begin
                    chk({tag, "_wdata"}, pmem_wdata, wd);
                    ref_mem[int'(a)] = wd;
                end else begin
                    chk({tag, "_rdata"}, (side == 0) ? i_rdata : d_rdata, ref_rd(a));
                end
                arb_last = side;
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: no resp within 300 cycles", tag);
        end
        repeat (1 + hold) @(posedge clk);
        #1;
        if (side == 0) begin i_read = 1'b0; i_write = 1'b0; end
        else begin d_read = 1'b0; d_write = 1'b0; end
    endtask

    typedef struct {
        bit ir, iw, dr, dw;
        int exp_fixed;   // -1 none, 0 icache, 1 dcache
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [127:0] IW, DW;
        int w, n0;
        bit got;

        IW = {4{32'h1CAC_4E11}};
        DW = {4{32'hDCAC_4E22}};
        tbl[0] = '{0, 0, 0, 0, -1};
        tbl[1] = '{1, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 0, 0};
        tbl[3] = '{0, 0, 1, 0, 1};
        tbl[4] = '{0, 0, 0, 1, 1};
        tbl[5] = '{1, 0, 1, 0, 1};
        tbl[6] = '{0, 1, 0, 1, 1};
        tbl[7] = '{1, 0, 0, 1, 1};

        // Reset state, with a request already pending.
        reset = 1'b1;
        i_read = 1'b1; i_write = 1'b0; i_address = 16'h0040; i_wdata = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = 16'h0000; d_wdata = '0;
        @(negedge clk);
        chk("rst_pmem_read", 128'(pmem_read), 128'(0));
        chk("rst_pmem_write", 128'(pmem_write), 128'(0));
        chk("rst_pmem_addr", 128'(pmem_address), 128'(0));
        chk("rst_pmem_wdata", pmem_wdata, 128'(0));
        chk("rst_i_resp", 128'(i_resp), 128'(0));
        chk("rst_d_resp", 128'(d_resp), 128'(0));
        i_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Grant table: first pmem cycle after a request seen in IDLE.
        lat = 2;
        for (int r = 0; r < 8; r++) begin
`ifdef PMEM_ARBITER_RR_EN
            w = (tbl[r].exp_fixed < 0) ? -1 : exp_winner(tbl[r].ir | tbl[r].iw, tbl[r].dr | tbl[r].dw);
`else
            w = tbl[r].exp_fixed;
`endif
            i_read = tbl[r].ir; i_write = tbl[r].iw; i_address = 16'h1110; i_wdata = IW;
            d_read = tbl[r].dr; d_write = tbl[r].dw; d_address = 16'h2220; d_wdata = DW;
            @(negedge clk);
            chk($sformatf("tbl%0d_idle", r), 128'(pmem_read | pmem_write), 128'(0));
            @(negedge clk);
            chk($sformatf("tbl%0d_read", r), 128'(pmem_read),
                128'((w == 0) ? tbl[r].ir : (w == 1) ? tbl[r].dr : 1'b0));
            chk($sformatf("tbl%0d_write", r), 128'(pmem_write),
                128'((w == 0) ? tbl[r].iw : (w == 1) ? tbl[r].dw : 1'b0));
            chk($sformatf("tbl%0d_addr", r), 128'(pmem_address),
                128'((w == 0) ? 16'h1110 : (w == 1) ? 16'h2220 : 16'h0000));
            chk($sformatf("tbl%0d_wdata", r), pmem_wdata, (w == 0) ? IW : (w == 1) ? DW : 128'(0));
            chk($sformatf("tbl%0d_early_resp", r), 128'(i_resp | d_resp), 128'(0));
            if (w >= 0) begin
                got = 1'b0;
                for (int k = 0; k < 50 && !got; k++) begin
                    @(negedge clk);
                    got = pmem_resp;
                end
                chk($sformatf("tbl%0d_i_resp", r), 128'(i_resp), 128'(w == 0));
                chk($sformatf("tbl%0d_d_resp", r), 128'(d_resp), 128'(w == 1));
                if (w == 0 && tbl[r].iw) ref_mem[int'(16'h1110)] = IW;
                if (w == 1 && tbl[r].dw) ref_mem[int'(16'h2220)] = DW;
                arb_last = w;
            end
            @(posedge clk); #1;
            i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
            @(posedge clk); #1;
        end

        // Lone icache read: pmem sees it one cycle after the request.
        lat = 3;
        log_q.delete();
        i_read = 1'b1; i_address = 16'h0040;
        @(negedge clk);
        chk("i40_cycle_n", 128'(pmem_read), 128'(0));
        @(negedge clk);
        chk("i40_cycle_n1_read", 128'(pmem_read), 128'(1));
        chk("i40_cycle_n1_addr", 128'(pmem_address), 128'(16'h0040));
        txn(0, 1'b0, 16'h0040, '0, 0);
        chk("i40_log", 128'(log_q.size() == 1 && log_q[0] == 0), 128'(1));

        // Lone dcache write then re-read of the same line.
        lat = 2;
        log_q.delete();
        txn(1, 1'b1, 16'h0120, {8{16'h600D}}, 0);
        txn(1, 1'b0, 16'h0120, '0, 0);
        chk("d120_reread", d_rdata, {8{16'h600D}});
        chk("d120_log", 128'(log_q.size() == 2 && log_q[0] == 1 && log_q[1] == 1), 128'(1));

        // Simultaneous reads, three rounds back to back.
        for (int rep = 0; rep < 3; rep++) begin
            w = exp_winner(1'b1, 1'b1);
            log_q.delete();
            fork
                txn(0, 1'b0, 16'h0A00 + 16'(rep * 16), '0, 0);
                txn(1, 1'b0, 16'h0B00 + 16'(rep * 16), '0, 0);
            join
            chk($sformatf("sim%0d_count", rep), 128'(log_q.size()), 128'(2));
            chk($sformatf("sim%0d_order", rep),
                128'(log_q.size() == 2 && log_q[0] == w && log_q[1] == 1 - w), 128'(1));
        end

        // Reset while the dcache read is outstanding.
        lat = 20;
        d_read = 1'b1; d_address = 16'h0300;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = pmem_read;
        end
        chk("rst_mid_granted", 128'(got), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_pmem_read", 128'(pmem_read), 128'(0));
        chk("rst_mid_d_resp", 128'(d_resp), 128'(0));
        d_read = 1'b0;
        n0 = log_q.size();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        arb_last = 0;
        lat = 2;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_resp", 128'(log_q.size()), 128'(n0));
        @(posedge clk); #1;
        txn(0, 1'b0, 16'h0000, '0, 0);

        // Held request after resp is re-granted; an on-time drop is not.
        lat = 1;
        n0 = n_reads;
        log_q.delete();
        txn(1, 1'b0, 16'h0500, '0, 2);
        repeat (4) @(negedge clk);
        chk("held_reads", 128'(n_reads - n0), 128'(2));
        chk("held_resps", 128'(log_q.size()), 128'(2));
        arb_last = 1;
        @(posedge clk); #1;
        n0 = n_reads;
        log_q.delete();
        txn(1, 1'b0, 16'h0500, '0, 0);
        repeat (4) @(negedge clk);
        chk("ontime_reads", 128'(n_reads - n0), 128'(1));
        chk("ontime_resps", 128'(log_q.size()), 128'(1));
        @(posedge clk); #1;

        // Randomized rounds against the reference memory and grant model.
        for (int r = 0; r < 60; r++) begin
            bit ir, dr, wi, wd;
            logic [15:0] ai, ad;
            logic [127:0] di, dd;
            lat = $urandom_range(1, 4);
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) dr = 1'b1;
            wi = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            ai = 16'($urandom_range(0, 2047)) << 4;
            ad = ai ^ 16'h8000;
            di = {$urandom, $urandom, $urandom, $urandom};
            dd = {$urandom, $urandom, $urandom, $urandom};
            w = exp_winner(ir, dr);
            log_q.delete();
            fork
                begin if (ir) txn(0, wi, ai, di, 0); end
                begin if (dr) txn(1, wd, ad, dd, 0); end
            join
            chk($sformatf("rnd%0d_count", r), 128'(log_q.size()), 128'(int'(ir) + int'(dr)));
            chk($sformatf("rnd%0d_first", r), 128'(log_q.size() > 0 && log_q[0] == w), 128'(1));
        end

        repeat (3) @(negedge clk);
        chk("mon_idle_gap", 128'(gap_err), 128'(0));
        chk("mon_both_resp", 128'(both_err), 128'(0));
        chk("mon_spurious_resp", 128'(spur_err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares one physical memory port between the instruction cache and the data cache.
- Each cache presents a line-granular read/write request: 16-bit address, 128-bit line.
- Holds at most one request in service at a time. Forwards the granted cache's request to pmem and routes pmem_resp back to that cache only.
- Sits between the two cache pmem ports and physical_memory at the top level.

Parameters:
- ADDR_WIDTH, 16, byte address width of cache and pmem ports.
- LINE_WIDTH, 128, cache line / pmem data width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_read  in  1  icache line-read request; held until i_resp.
- i_write  in  1  icache line-write request; held until i_resp (unused by current icache but supported).
- i_address  in  ADDR_WIDTH  icache line address.
- i_wdata  in  LINE_WIDTH  icache writeback data.
- i_resp  out  1  icache transaction complete.
- i_rdata  out  LINE_WIDTH  line read data.
- d_read  in  1  dcache line-read request.
- d_write  in  1  dcache line-write (writeback) request.
- d_address  in  ADDR_WIDTH  dcache line address.
- d_wdata  in  LINE_WIDTH  dcache writeback data.
- d_resp  out  1  dcache transaction complete.
- d_rdata  out  LINE_WIDTH  line read data.
- pmem_read  out  1  read to physical memory.
- pmem_write  out  1  write to physical memory.
- pmem_address  out  ADDR_WIDTH  physical memory address.
- pmem_wdata  out  LINE_WIDTH  physical memory write data.
- pmem_resp  in  1  physical memory done.
- pmem_rdata  in  LINE_WIDTH  physical memory read data.

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Registered state; async reset to IDLE.
- Reset values: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=0, d_resp=0.
- IDLE:
  - pmem_read/write=0; address/wdata driven 0.
  - Next state computed from (i_read|i_write) and (d_read|d_write).
  - Default: d has priority over i. Neither requesting: stay IDLE.
- SERVE_X:
  - pmem_read=X_read, pmem_write=X_write, pmem_address=X_address, pmem_wdata=X_wdata, all combinational from the granted requester.
  - X_resp=pmem_resp combinationally. The other requester's resp is held 0.
  - On pmem_resp=1, next state is IDLE unconditionally.
- Latency: a request arriving in IDLE at cycle n drives pmem at cycle n+1. resp is seen in the same cycle as pmem_resp. One mandatory IDLE cycle follows each completion, so a requester that drops its request on the edge after resp is never re-granted with a stale request.
- i_rdata and d_rdata are both driven by pmem_rdata at all times; only resp qualifies them.
- Simultaneous requests in IDLE: one is granted, per the priority rule. The loser keeps its request asserted and is served after the winner's completion plus the IDLE cycle.
- Requester drops its request while granted: protocol violation. pmem signals follow the inputs (go to 0); FSM stays in SERVE_X until pmem_resp.
- Same requester asserts read and write together: illegal. Both are forwarded unmodified; a simulation-only assertion flags it.
- Reset mid-transaction: state goes to IDLE immediately, pmem_read/write drop asynchronously. Caches and physical memory are reset on the same signal.
- No buffering: the arbiter holds no data registers. State is its only storage.

Optional Feature:
- Macro: PMEM_ARBITER_RR_EN.
- Defined:
  - Adds a 1-bit last_grant register, reset to I.
  - On simultaneous requests in IDLE, the requester not in last_grant wins.
  - last_grant updates on every SERVE_x→IDLE transition.
  - Starvation bound: one transaction.
- Undefined: fixed d-over-i priority as above; no extra flop.

Decomposition:
- Package pmem_arbiter_pkg:
  - Enum arb_state_t {IDLE, SERVE_I, SERVE_D}.
  - Enum arb_req_t {REQ_I, REQ_D}.
  - Localparams for default ADDR_WIDTH and LINE_WIDTH.
- Sub-module pmem_arbiter_select: purely combinational next-grant function taking i_req, d_req and last_grant, returning the grant. This isolates the priority/round-robin policy so it can be swapped without touching the FSM or muxing.

Test Plan:
- Lone icache read, i_address=16'h0040:
  - pmem_read=1 with address 16'h0040 at cycle+1.
  - i_resp pulses with pmem_resp; i_rdata equals the memory line.
  - d_resp stays 0.
- Lone dcache write, d_address=16'h0120, d_wdata=128'h600D…600D:
  - pmem_write=1 with matching address/data.
  - d_resp on completion; a re-read of 16'h0120 returns the written line.
- i_read and d_read raised the same cycle:
  - Without RR: d served first, then one IDLE cycle, then i. Exactly one resp pulse each, in that order.
- Same as previous with PMEM_ARBITER_RR_EN, repeated three times back-to-back:
  - Grant order I-wait… D, I, D, I, D, I: first D (last_grant reset=I), then alternation.
- Reset asserted while in SERVE_D mid-read:
  - pmem_read falls in the same timestep, no d_resp.
  - After release, a fresh i_read at 16'h0000 completes normally.
- dcache holds d_read after resp for an extra cycle:
  - The IDLE gap re-evaluates it and issues a second read (documents the held-request hazard).
  - A requester dropping on time issues no second read.
